// File: rtl/sb_pkg.sv
// Shared definitions for the store buffer: entry layout, default geometry
// and the address-index helper used by the buffer and its match logic.
package sb_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_AW    = 10;
  localparam int unsigned SB_PTR_W = $clog2(SB_DEPTH);

  // addr is held zero-extended to 32 bits; only the low AW bits are ever
  // non-zero, so unused upper flops are constant and fall away.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_entry_t;

  // Keep the memory index bits of a word address, clear the rest.
  function automatic logic [31:0] sb_idx_addr(input logic [31:0] a,
                                              input int unsigned aw);
    logic [63:0] mask;
    mask = (64'd1 << aw) - 64'd1;
    return a & mask[31:0];
  endfunction

endpackage

// File: rtl/sb_match.sv
// Youngest-match search over the store buffer entries.
// Ports:
//   entries  in   buffer storage (physical slots)
//   head     in   slot of the oldest valid entry
//   count    in   number of valid entries
//   addr     in   load word address (upper bits beyond AW ignored)
//   hit      out  some valid entry matches addr
//   idx      out  slot of the youngest matching entry (valid when hit)
module sb_match
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [PW-1:0]     head,
  input  logic [PW:0]       count,
  input  logic [31:0]       addr,
  output logic              hit,
  output logic [PW-1:0]     idx
);

  logic [31:0]   key;
  logic [PW-1:0] slot;

  // Walk from oldest (age 0 at head) to youngest; a later match overrides
  // an earlier one, so the last hit seen is the youngest.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    key  = sb_idx_addr(addr, AW);
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = head + PW'(k);
      if (((PW+1)'(k) < count) && (entries[slot].addr == key)) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM stage and word-addressed data memory.
// Stores enter an in-order FIFO and drain one per cycle when the port is
// free; loads forward from the youngest matching buffered store.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   memWrite/Read   MEM-stage store / load request (mutually exclusive)
//   address         word index; bits above AW ignored for matching
//   writeData       store data
//   sync            fence: stall until the buffer is empty
//   readData        load result (combinational)
//   stall           pipeline hold (combinational)
//   dmemBusy        memory port owned by another master this cycle
//   dmemReadData    memory read data, combinational on dmemAddress
//   dmemAddress     memory port address
//   dmemWriteData   memory port write data
//   dmemWrite       write strobe (memory commits on following negedge)
//   dmemRead        read strobe
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        sync,
  output logic [31:0] readData,
  output logic        stall,
  input  logic        dmemBusy,
  input  logic [31:0] dmemReadData,
  output logic [31:0] dmemAddress,
  output logic [31:0] dmemWriteData,
  output logic        dmemWrite,
  output logic        dmemRead
);

  localparam int unsigned PW       = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  sb_entry_t     entries_q [DEPTH];
  sb_entry_t     entries_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic          match_hit;
  logic [PW-1:0] match_idx;

  logic hit;
  logic miss_go;
  logic drain;
  logic full;
  logic accept;

  sb_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_match (
    .entries (entries_q),
    .head    (head_q),
    .count   (count_q),
    .addr    (address),
    .hit     (match_hit),
    .idx     (match_idx)
  );

  // Port arbitration: a missing load owns the port; draining takes it
  // otherwise. Stall includes the drain term so that a full buffer can pop
  // and push in the same cycle without holding the pipeline.
  always_comb begin
    hit     = memRead && match_hit;
    miss_go = memRead && !match_hit && !dmemBusy;
    full    = (count_q == CNT_FULL);
    drain   = (count_q != '0) && !dmemBusy && !miss_go;
    stall   = (memWrite && full && !drain) ||
              (memRead && !match_hit && dmemBusy) ||
              (sync && (count_q != '0));
    accept  = memWrite && !stall;
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (accept) begin
      entries_d[tail_q] = '{addr: sb_idx_addr(address, AW), data: writeData};
      tail_d            = tail_q + PTR_ONE;
    end
    if (drain) begin
      head_d = head_q + PTR_ONE;
    end
    if (accept && !drain) begin
      count_d = count_q + CNT_ONE;
    end else if (!accept && drain) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: validity comes from head/count only.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  always_comb begin
    readData      = '0;
    dmemAddress   = '0;
    dmemWriteData = '0;
    dmemWrite     = 1'b0;
    dmemRead      = 1'b0;
    if (hit) begin
      readData = entries_q[match_idx].data;
    end else if (miss_go) begin
      readData = dmemReadData;
    end
    if (miss_go) begin
      dmemRead    = 1'b1;
      dmemAddress = address;
    end else if (drain) begin
      dmemWrite     = 1'b1;
      dmemAddress   = entries_q[head_q].addr;
      dmemWriteData = entries_q[head_q].data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  logic        clk;
  logic        rst;
  logic        memWrite;
  logic        memRead;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        sync;
  logic [31:0] readData;
  logic        stall;
  logic        dmemBusy;
  logic [31:0] dmemReadData;
  logic [31:0] dmemAddress;
  logic [31:0] dmemWriteData;
  logic        dmemWrite;
  logic        dmemRead;

  int checks = 0;
  int errors = 0;

  store_buffer #(
    .DEPTH (4),
    .AW    (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .memWrite      (memWrite),
    .memRead       (memRead),
    .address       (address),
    .writeData     (writeData),
    .sync          (sync),
    .readData      (readData),
    .stall         (stall),
    .dmemBusy      (dmemBusy),
    .dmemReadData  (dmemReadData),
    .dmemAddress   (dmemAddress),
    .dmemWriteData (dmemWriteData),
    .dmemWrite     (dmemWrite),
    .dmemRead      (dmemRead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: combinational read, write on negedge.
  logic [31:0] mem [1024];
  logic        mem_ready = 1'b0;
  assign dmemReadData = mem[dmemAddress[9:0]];

  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[10'h011] <= 32'h0000_1234;
      mem[10'h040] <= 32'h0000_4040;
      mem[10'h061] <= 32'h0000_6161;
      mem_ready    <= 1'b1;
    end else if (dmemWrite) begin
      mem[dmemAddress[9:0]] <= dmemWriteData;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after posedge; returns before negedge.
  task automatic step(input logic r, input logic mw, input logic mr,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic sy, input logic bz);
    @(posedge clk);
    #1;
    rst = r; memWrite = mw; memRead = mr; address = a;
    writeData = wd; sync = sy; dmemBusy = bz;
    #3;
  endtask

  typedef struct {
    logic        mw, mr;
    logic [31:0] addr, wd;
    logic        sy, bz;
    logic        ex_stall;
    logic [31:0] ex_rd;
    logic        ex_dw, ex_dr;
    logic [31:0] ex_da, ex_dwd;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  logic [31:0] ea [4];
  logic [31:0] ed [4];
  int          n;

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //          mw mr addr        wd          sy bz  stall rd           dw dr da          dwd
    vecs[0]  = '{0, 0, 32'h0,     32'h0,      0, 0,  0,    32'h0,       0, 0, 32'h0,      32'h0};
    vecs[1]  = '{1, 0, 32'h10,    32'hAAAA,   0, 0,  0,    32'h0,       0, 0, 32'h0,      32'h0};
    vecs[2]  = '{0, 1, 32'h11,    32'h0,      0, 0,  0,    32'h1234,    0, 1, 32'h11,     32'h0};
    vecs[3]  = '{0, 0, 32'h0,     32'h0,      0, 0,  0,    32'h0,       1, 0, 32'h10,     32'hAAAA};
    vecs[4]  = '{0, 1, 32'h10,    32'h0,      0, 0,  0,    32'hAAAA,    0, 1, 32'h10,     32'h0};
    vecs[5]  = '{1, 0, 32'h5,     32'h7,      0, 1,  0,    32'h0,       0, 0, 32'h0,      32'h0};
    vecs[6]  = '{1, 0, 32'h5,     32'h9,      0, 1,  0,    32'h0,       0, 0, 32'h0,      32'h0};
    vecs[7]  = '{0, 1, 32'h5,     32'h0,      0, 1,  0,    32'h9,       0, 0, 32'h0,      32'h0};
    vecs[8]  = '{0, 1, 32'h405,   32'h0,      0, 1,  0,    32'h9,       0, 0, 32'h0,      32'h0};
    vecs[9]  = '{0, 1, 32'h6,     32'h0,      0, 1,  1,    32'h0,       0, 0, 32'h0,      32'h0};
    vecs[10] = '{0, 1, 32'h5,     32'h0,      0, 0,  0,    32'h9,       1, 0, 32'h5,      32'h7};
    vecs[11] = '{0, 0, 32'h0,     32'h0,      0, 0,  0,    32'h0,       1, 0, 32'h5,      32'h9};
    vecs[12] = '{0, 1, 32'h5,     32'h0,      0, 0,  0,    32'h9,       0, 1, 32'h5,      32'h0};

    rst = 1'b1; memWrite = 1'b0; memRead = 1'b0; address = '0;
    writeData = '0; sync = 1'b0; dmemBusy = 1'b0;

    // Reset
    step(1, 0, 0, 32'h0, 32'h0, 0, 0);
    step(1, 0, 0, 32'h0, 32'h0, 0, 0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_dw", {31'h0, dmemWrite}, 32'h0);
    chk("rst_dr", {31'h0, dmemRead}, 32'h0);
    chk("rst_da", dmemAddress, 32'h0);
    chk("rst_rd", readData, 32'h0);

    // Table: store/miss-load/drain, then forwarding
    for (int i = 0; i < NV; i++) begin
      step(0, vecs[i].mw, vecs[i].mr, vecs[i].addr, vecs[i].wd, vecs[i].sy, vecs[i].bz);
      chk($sformatf("v%0d_stall", i), {31'h0, stall}, {31'h0, vecs[i].ex_stall});
      chk($sformatf("v%0d_rd", i), readData, vecs[i].ex_rd);
      chk($sformatf("v%0d_dw", i), {31'h0, dmemWrite}, {31'h0, vecs[i].ex_dw});
      chk($sformatf("v%0d_dr", i), {31'h0, dmemRead}, {31'h0, vecs[i].ex_dr});
      chk($sformatf("v%0d_da", i), dmemAddress, vecs[i].ex_da);
      chk($sformatf("v%0d_dwd", i), dmemWriteData, vecs[i].ex_dwd);
    end

    // Full buffer, duplicate address, simultaneous pop/push
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 32'h20 + i, 32'h100 + i, 0, 1);
      chk($sformatf("full_st%0d_stall", i), {31'h0, stall}, 32'h0);
    end
    step(0, 1, 0, 32'h20, 32'h104, 0, 1);
    chk("full_st4_stall", {31'h0, stall}, 32'h1);
    step(0, 1, 0, 32'h20, 32'h104, 0, 1);
    chk("full_hold_stall", {31'h0, stall}, 32'h1);
    step(0, 1, 0, 32'h20, 32'h104, 0, 0);
    chk("full_rel_stall", {31'h0, stall}, 32'h0);
    chk("full_rel_dw", {31'h0, dmemWrite}, 32'h1);
    chk("full_rel_da", dmemAddress, 32'h20);
    chk("full_rel_dwd", dmemWriteData, 32'h100);
    ea[0] = 32'h21; ea[1] = 32'h22; ea[2] = 32'h23; ea[3] = 32'h20;
    ed[0] = 32'h101; ed[1] = 32'h102; ed[2] = 32'h103; ed[3] = 32'h104;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 32'h0, 32'h0, 0, 0);
      chk($sformatf("full_dr%0d_dw", i), {31'h0, dmemWrite}, 32'h1);
      chk($sformatf("full_dr%0d_da", i), dmemAddress, ea[i]);
      chk($sformatf("full_dr%0d_dwd", i), dmemWriteData, ed[i]);
    end
    step(0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk("full_empty_dw", {31'h0, dmemWrite}, 32'h0);
    step(0, 1'b0, 1'b1, 32'h20, 32'h0, 0, 0);
    chk("full_mem_youngest", readData, 32'h104);

    // Port contention: miss load beats drain
    step(0, 1, 0, 32'h30, 32'h1, 0, 1);
    step(0, 1, 0, 32'h31, 32'h2, 0, 1);
    step(0, 0, 1, 32'h40, 32'h0, 0, 0);
    chk("port_dr", {31'h0, dmemRead}, 32'h1);
    chk("port_dw", {31'h0, dmemWrite}, 32'h0);
    chk("port_da", dmemAddress, 32'h40);
    chk("port_rd", readData, 32'h4040);
    step(0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk("port_d0_da", dmemAddress, 32'h30);
    chk("port_d0_dwd", dmemWriteData, 32'h1);
    step(0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk("port_d1_da", dmemAddress, 32'h31);
    chk("port_d1_dwd", dmemWriteData, 32'h2);
    step(0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk("port_done_dw", {31'h0, dmemWrite}, 32'h0);

    // Sync with 3 entries: stall exactly 3 cycles
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h50 + i, 32'h500 + i, 0, 1);
    n = 0;
    for (int c = 0; c < 8; c++) begin
      step(0, 0, 0, 32'h0, 32'h0, 1, 0);
      if (stall) n++;
      else break;
    end
    chk("sync_cycles", n, 32'd3);
    chk("sync_end_stall", {31'h0, stall}, 32'h0);
    chk("sync_end_dw", {31'h0, dmemWrite}, 32'h0);

    // Reset during a drain: the in-flight write still lands
    step(0, 1, 0, 32'h60, 32'h600, 0, 1);
    step(0, 1, 0, 32'h61, 32'h601, 0, 1);
    step(1, 0, 0, 32'h0, 32'h0, 0, 0);
    chk("rstd_dw", {31'h0, dmemWrite}, 32'h1);
    chk("rstd_da", dmemAddress, 32'h60);
    step(0, 0, 0, 32'h0, 32'h0, 0, 0);
    chk("rstd_idle_dw", {31'h0, dmemWrite}, 32'h0);
    chk("rstd_idle_dr", {31'h0, dmemRead}, 32'h0);
    chk("rstd_idle_stall", {31'h0, stall}, 32'h0);
    chk("rstd_idle_da", dmemAddress, 32'h0);
    chk("rstd_idle_dwd", dmemWriteData, 32'h0);
    chk("rstd_idle_rd", readData, 32'h0);
    step(0, 0, 1, 32'h61, 32'h0, 0, 0);
    chk("rstd_ld61_dr", {31'h0, dmemRead}, 32'h1);
    chk("rstd_ld61_rd", readData, 32'h6161);
    step(0, 0, 1, 32'h60, 32'h0, 0, 0);
    chk("rstd_ld60_rd", readData, 32'h600);

    step(0, 0, 0, 32'h0, 32'h0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the pipeline MEM stage and the word-addressed data memory. Stores retire into a small in-order FIFO and drain to memory one per cycle whenever the memory port is free. Loads check the buffer first; the youngest matching buffered store is forwarded, so the pipeline never reads stale data. A stall output holds the pipeline only when the buffer is full and cannot drain, when a missing load cannot get the port, or during a sync.

## Interface
- DEPTH, 4: buffer entries, power of two, 2..16
- AW, 10: memory index bits used (address[AW-1:0]); upper address bits ignored
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- memWrite  in  1  MEM-stage store request
- memRead  in  1  MEM-stage load request; never asserted with memWrite
- address  in  32  word index from the ALU
- writeData  in  32  store data
- sync  in  1  fence: hold the pipeline until the buffer is empty
- readData  out  32  load result, combinational
- stall  out  1  pipeline hold, combinational
- dmemBusy  in  1  memory port taken by another master this cycle
- dmemReadData  in  32  data memory read data, combinational on dmemAddress
- dmemAddress  out  32  memory port address
- dmemWriteData  out  32  memory port write data
- dmemWrite  out  1  memory write strobe; memory commits on the following negedge
- dmemRead  out  1  memory read strobe

## Operation
- State: DEPTH entries {addr[AW-1:0], data[31:0]}, head/tail pointers, count 0..DEPTH.
- Hit: memRead and some valid entry addr == address[AW-1:0]. The youngest such entry (closest to tail) supplies readData. The memory port is not needed.
- Miss load: memRead, no hit, !dmemBusy. Drive dmemRead=1 and dmemAddress=address. readData=dmemReadData.
- Miss load with dmemBusy: stall=1 and readData=0.
- Drain: when count>0, !dmemBusy and the port is not used by a miss load, drive dmemWrite=1 with the head entry. At posedge pop the head (head+1, wrapping mod DEPTH).
- Accept: memWrite && !stall. At posedge write the entry at tail, then tail+1 (wrap).
- Port priority: miss load over drain. Drain is allowed during a hit load or a store.
- stall = (memWrite && count==DEPTH && !drain) || (memRead && !hit && dmemBusy) || (sync && count!=0).
- Full with a simultaneous drain and store: pop and push happen in the same cycle, count stays DEPTH, and there is no stall.
- Duplicate addresses are appended with no coalescing. Drain order equals program order, so memory ends with the youngest value.
- Idle outputs: dmemAddress=0, dmemWriteData=0, dmemWrite=0, dmemRead=0, readData=0.

## Timing
- Hit and miss loads are zero-latency: readData is valid in the same cycle as memRead.
- A store is visible to loads from the cycle after it is accepted.
- A drained entry remains forwardable during its drain cycle. Memory holds the value from the following negedge.
- The earliest drain of an entry is the cycle after it is accepted, so the minimum residency is 1 cycle.
- Reset: count=0, head=tail=0, all outputs take their idle values. Buffered stores are discarded.
- A reset asserted during a drain cycle still lets that negedge write complete, because dmemWrite was already high. No drain is issued in the cycle after reset.

## Structure
- The shared package sb_pkg holds:
  - the entry struct typedef
  - the DEPTH and AW defaults
  - the pointer width, $clog2(DEPTH)
- One sub-module, sb_match: a combinational youngest-match priority search over the entries. It outputs hit and the matching index, with age ordering computed relative to head.
- The FIFO storage and control stay in store_buffer.

## Test plan
- **Store then load, different address:** store 0x10←0xAAAA, then load 0x11 with dmemReadData=0x1234 → readData=0x1234, dmemRead=1. Next idle cycle: dmemWrite=1, dmemAddress=0x10.
- **Forwarding:** with dmemBusy=1, store 5←7, then store 5←9, then load 5 → readData=9, dmemRead=0, stall=0.
- **Full buffer:** with dmemBusy=1, issue 5 stores → stall=1 on the fifth, count=4. Release dmemBusy → the fifth store is accepted in the same cycle as the first drain. Memory ends with values in program order.
- **Port contention:** 2 entries buffered, miss load with dmemBusy=0 → the load owns the port and dmemWrite=0. The drain resumes next cycle.
- **Sync:** 3 entries buffered, sync=1 → stall=1 for exactly 3 cycles, then stall=0 with count=0.
- **Reset:** assert rst with 2 entries buffered → the next cycle shows count=0, all outputs 0, and a later load of a buffered address reads from memory.
